dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: round-robin grant,
// one transaction in flight, read-modify-write for partial stores.
module dm_arbiter #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic        req_we_0,
    input  logic [31:0] req_addr_0,
    input  logic [31:0] req_wdata_0,
    input  logic [3:0]  req_be_0,
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic        req_we_1,
    input  logic [31:0] req_addr_1,
    input  logic [31:0] req_wdata_1,
    input  logic [3:0]  req_be_1,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    // Handshake: a request is accepted at a posedge where req_valid_x and
    // req_ready_x are both high; the requester holds valid and payload until then.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [31:0] WORDS_L = 32'(WORDS);

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic        lat_port_q;
    logic        lat_we_q;
    logic [29:0] lat_waddr_q;
    logic [31:0] lat_wdata_q;
    logic [3:0]  lat_be_q;
    logic [31:0] merge_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        grant_0, grant_1;
    logic        in_range;
    logic        be_full, be_none;
    logic [31:0] merged_wdata;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (state_q == IDLE) begin
            grant_0 = req_valid_0 && (!req_valid_1 || last_grant_q);
            grant_1 = req_valid_1 && (!req_valid_0 || !last_grant_q);
        end
    end

    assign in_range = {2'b00, lat_waddr_q} < WORDS_L;
    assign be_full  = &lat_be_q;
    assign be_none  = ~|lat_be_q;

    always_comb begin
        merged_wdata = '0;
        for (int n = 0; n < 4; n++) begin
            merged_wdata[8*n +: 8] = lat_be_q[n] ? lat_wdata_q[8*n +: 8] : merge_q[8*n +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_0 || grant_1) state_d = ACCESS;
            ACCESS: begin
                if (in_range && lat_we_q && !be_full && !be_none) state_d = MERGE;
                else                                               state_d = RESP;
            end
            MERGE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        rsp_valid_0 = 1'b0;
        rsp_valid_1 = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = lat_wdata_q;
        if (rst_n) begin
            req_ready_0 = grant_0;
            req_ready_1 = grant_1;
            case (state_q)
                ACCESS: mem_write = in_range && lat_we_q && be_full;
                MERGE: begin
                    mem_write = 1'b1;
                    mem_wdata = merged_wdata;
                end
                RESP: begin
                    rsp_valid_0 = !lat_port_q;
                    rsp_valid_1 = lat_port_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = {lat_waddr_q, 2'b00};
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            lat_port_q   <= 1'b0;
            lat_we_q     <= 1'b0;
            lat_waddr_q  <= '0;
            lat_wdata_q  <= '0;
            lat_be_q     <= '0;
            merge_q      <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (grant_0 || grant_1) begin
                last_grant_q <= grant_1;
                lat_port_q   <= grant_1;
                lat_we_q     <= grant_1 ? req_we_1          : req_we_0;
                lat_waddr_q  <= grant_1 ? req_addr_1[31:2]  : req_addr_0[31:2];
                lat_wdata_q  <= grant_1 ? req_wdata_1       : req_wdata_0;
                lat_be_q     <= grant_1 ? req_be_1          : req_be_0;
            end
            if (state_q == ACCESS) begin
                rsp_err_q   <= !in_range;
                rsp_rdata_q <= (in_range && !lat_we_q) ? mem_rdata : 32'h0;
                if (in_range && lat_we_q && !be_full && !be_none) merge_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 64-word memory attached.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_0 = 1'b0, req_we_0 = 1'b0;
    logic        req_valid_1 = 1'b0, req_we_1 = 1'b0;
    logic [31:0] req_addr_0 = '0, req_wdata_0 = '0, req_addr_1 = '0, req_wdata_1 = '0;
    logic [3:0]  req_be_0 = '0, req_be_1 = '0;
    logic        req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_err, mem_write;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    dm_arbiter #(.WORDS(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0), .req_be_0(req_be_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1), .req_be_1(req_be_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Memory model plus write/response counters.
    logic [31:0] mem [0:63];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;
    int          wr_total = 0;
    int          rsp_total = 0;
    logic [1:0]  wr_state = '0;

    assign mem_rdata = (mem_addr[31:8] == 24'h0) ? mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (mem_write && mem_addr[31:8] == 24'h0) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_write) begin
            wr_total <= wr_total + 1;
            wr_state <= dbg_state;
        end
        if (rsp_valid_0 || rsp_valid_1) rsp_total <= rsp_total + 1;
    end

    int n_checks = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        bd_we = 1'b1; bd_idx = 6'(idx); bd_data = data;
        tick;
        bd_we = 1'b0;
    endtask

    task automatic set_req(input int port, input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        if (port == 0) begin
            req_valid_0 = v; req_we_0 = we; req_addr_0 = addr; req_wdata_0 = wdata; req_be_0 = be;
        end else begin
            req_valid_1 = v; req_we_1 = we; req_addr_1 = addr; req_wdata_1 = wdata; req_be_1 = be;
        end
    endtask

    // lat is the number of edges from the accept edge to the edge that samples rsp_valid high.
    task automatic issue(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int writes, output logic [1:0] wstate);
        int base_wr;
        int n;
        logic rdy, mine, other;
        set_req(port, 1'b1, we, addr, wdata, be);
        #1;
        n = 0;
        rdy = (port == 0) ? req_ready_0 : req_ready_1;
        while (!rdy && n < 20) begin
            tick;
            n++;
            rdy = (port == 0) ? req_ready_0 : req_ready_1;
        end
        check("accept_ready", 32'(rdy), 32'd1);
        base_wr = wr_total;
        tick;
        set_req(port, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n = 0;
        mine = (port == 0) ? rsp_valid_0 : rsp_valid_1;
        while (!mine && n < 10) begin
            tick;
            n++;
            mine = (port == 0) ? rsp_valid_0 : rsp_valid_1;
        end
        lat = n + 1;
        rdata = rsp_rdata;
        err = rsp_err;
        other = (port == 0) ? rsp_valid_1 : rsp_valid_0;
        check("rsp_other_port", 32'(other), 32'd0);
        tick;
        check("rsp_one_cycle", 32'({rsp_valid_0, rsp_valid_1}), 32'd0);
        check("back_to_idle", 32'(dbg_state), 32'd0);
        writes = wr_total - base_wr;
        wstate = wr_state;
    endtask

    initial begin
        int lat, writes, got, last_cyc, base_wr, base_rsp;
        logic [31:0] rdata, exp_port;
        logic err;
        logic [1:0] wstate;

        // Reset: outputs gated even with a valid request pending.
        set_req(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        poke(5, 32'hDEADBEEF);
        poke(3, 32'h11223344);
        poke(9, 32'h55555555);
        #1;
        check("rst_ready_0", 32'(req_ready_0), 32'd0);
        check("rst_ready_1", 32'(req_ready_1), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_rsp_valid", 32'({rsp_valid_0, rsp_valid_1}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", 32'(rsp_err), 32'd0);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b1;
        tick;

        issue(0, 1'b0, 32'h14, 32'h0, 4'h0, lat, rdata, err, writes, wstate);
        check("load_lat", 32'(lat), 32'd2);
        check("load_rdata", rdata, 32'hDEADBEEF);
        check("load_err", 32'(err), 32'd0);
        check("load_writes", 32'(writes), 32'd0);

        issue(1, 1'b1, 32'h0C, 32'hAABBCCDD, 4'b0101, lat, rdata, err, writes, wstate);
        check("pstore_lat", 32'(lat), 32'd3);
        check("pstore_writes", 32'(writes), 32'd1);
        check("pstore_wr_state", 32'(wstate), 32'd2);
        check("pstore_mem", mem[3], 32'h11BB33DD);
        check("pstore_rdata", rdata, 32'h0);

        issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, lat, rdata, err, writes, wstate);
        check("fstore_lat", 32'(lat), 32'd2);
        check("fstore_writes", 32'(writes), 32'd1);
        check("fstore_wr_state", 32'(wstate), 32'd1);
        check("fstore_mem", mem[8], 32'hCAFEF00D);

        issue(1, 1'b1, 32'h27, 32'hFFFFFFFF, 4'b0000, lat, rdata, err, writes, wstate);
        check("estore_lat", 32'(lat), 32'd2);
        check("estore_writes", 32'(writes), 32'd0);
        check("estore_mem", mem[9], 32'h55555555);
        check("estore_rdata", rdata, 32'h0);

        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, lat, rdata, err, writes, wstate);
        check("oor_load_lat", 32'(lat), 32'd2);
        check("oor_load_err", 32'(err), 32'd1);
        check("oor_load_rdata", rdata, 32'h0);
        check("oor_load_writes", 32'(writes), 32'd0);

        issue(1, 1'b1, 32'h104, 32'h12345678, 4'b1111, lat, rdata, err, writes, wstate);
        check("oor_store_err", 32'(err), 32'd1);
        check("oor_store_writes", 32'(writes), 32'd0);

        issue(1, 1'b0, 32'h22, 32'h0, 4'h0, lat, rdata, err, writes, wstate);
        check("load8_rdata", rdata, 32'hCAFEF00D);
        check("load8_err_clear", 32'(err), 32'd0);

        // Fairness: both ports valid straight out of reset.
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick;
        rst_n = 1'b1;
        #1;
        check("tie_ready_0", 32'(req_ready_0), 32'd1);
        check("tie_ready_1", 32'(req_ready_1), 32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        got = 0;
        last_cyc = -1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            tick;
            if (rsp_valid_0 || rsp_valid_1) begin
                exp_port = exp_q.pop_front();
                check("fair_grant", 32'(rsp_valid_1), exp_port);
                check("fair_rdata", rsp_rdata, (exp_port == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
                if (last_cyc >= 0) check("fair_spacing", 32'(c - last_cyc), 32'd3);
                last_cyc = c;
                got++;
            end
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("fair_count", 32'(got), 32'd4);
        tick;
        tick;

        // Reset while in MERGE abandons the read-modify-write.
        base_wr = wr_total;
        base_rsp = rsp_total;
        set_req(0, 1'b1, 1'b1, 32'h0C, 32'h99000000, 4'b1000);
        #1;
        check("mrst_ready", 32'(req_ready_0), 32'd1);
        tick;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("mrst_access", 32'(dbg_state), 32'd1);
        tick;
        check("mrst_merge", 32'(dbg_state), 32'd2);
        check("mrst_merge_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_write_gated", 32'(mem_write), 32'd0);
        tick;
        check("mrst_idle", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick;
        tick;
        check("mrst_no_write", 32'(wr_total - base_wr), 32'd0);
        check("mrst_no_rsp", 32'(rsp_total - base_rsp), 32'd0);
        check("mrst_mem", mem[3], 32'h11BB33DD);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
